// File: rtl/ext_pipe_if.sv
// ext_pipe_if: valid/ready bus between the immediate source, ext_pipe and its consumer.
// Build with EXT_ERR_EN defined to add the out_err range-check flag.
interface ext_pipe_if #(
    parameter int IN_W  = 26,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [2:0]       out_op;
`ifdef EXT_ERR_EN
    logic             out_err;
    modport slave  (input in_valid, in_imm, in_op, out_ready, output in_ready, out_valid, out_data, out_op, out_err);
    modport master (output in_valid, in_imm, in_op, out_ready, input in_ready, out_valid, out_data, out_op, out_err);
`else
    modport slave  (input in_valid, in_imm, in_op, out_ready, output in_ready, out_valid, out_data, out_op);
    modport master (output in_valid, in_imm, in_op, out_ready, input in_ready, out_valid, out_data, out_op);
`endif
endinterface

// File: rtl/ext_pipe.sv
// ext_pipe: two-stage valid/ready immediate extender (ZE/SE/LUI/BR/J/SEB/SEH).
// Define EXT_ERR_EN to register an out-of-range flag alongside the result.
module ext_pipe #(
    parameter int IN_W  = 26,
    parameter int OUT_W = 32
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   flush,
    ext_pipe_if.slave bus
);
    localparam logic [OUT_W-1:0] M26 = OUT_W'(64'h3FF_FFFF);

    logic             s1_v_q, s1_v_d;
    logic [IN_W-1:0]  s1_imm_q, s1_imm_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic             s2_v_q, s2_v_d;
    logic [OUT_W-1:0] s2_data_q, s2_data_d;
    logic [2:0]       s2_op_q, s2_op_d;
    logic             s1_adv, s2_adv;
    logic [OUT_W-1:0] wide, se16, ze26, res;

    always_comb begin
        wide = OUT_W'(s1_imm_q);
        se16 = {{(OUT_W-16){s1_imm_q[15]}}, s1_imm_q[15:0]};
        ze26 = wide & M26;
        case (s1_op_q)
            3'd0:    res = OUT_W'(s1_imm_q[15:0]);
            3'd1:    res = se16;
            3'd2:    res = ze26;
            3'd3:    res = OUT_W'({s1_imm_q[15:0], 16'h0000});
            3'd4:    res = se16 << 2;
            3'd5:    res = ze26 << 2;
            3'd6:    res = {{(OUT_W-8){s1_imm_q[7]}}, s1_imm_q[7:0]};
            default: res = se16;
        endcase
    end

    // Stalled stages hold; flush only clears the valid bits.
    always_comb begin
        s2_adv    = !s2_v_q || bus.out_ready;
        s1_adv    = !s1_v_q || s2_adv;
        s1_v_d    = flush ? 1'b0 : (s1_adv ? bus.in_valid : s1_v_q);
        s1_imm_d  = (s1_adv && bus.in_valid) ? bus.in_imm : s1_imm_q;
        s1_op_d   = (s1_adv && bus.in_valid) ? bus.in_op : s1_op_q;
        s2_v_d    = flush ? 1'b0 : (s2_adv ? s1_v_q : s2_v_q);
        s2_data_d = (s2_adv && s1_v_q) ? res : s2_data_q;
        s2_op_d   = (s2_adv && s1_v_q) ? s1_op_q : s2_op_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q    <= 1'b0;
            s1_imm_q  <= '0;
            s1_op_q   <= '0;
            s2_v_q    <= 1'b0;
            s2_data_q <= '0;
            s2_op_q   <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_imm_q  <= s1_imm_d;
            s1_op_q   <= s1_op_d;
            s2_v_q    <= s2_v_d;
            s2_data_q <= s2_data_d;
            s2_op_q   <= s2_op_d;
        end
    end

`ifdef EXT_ERR_EN
    logic err, s2_err_q, s2_err_d;

    always_comb begin
        err = ((s1_op_q == 3'd2 || s1_op_q == 3'd5) && |(wide & ~M26)) || (s1_op_q == 3'd3 && OUT_W < 32);
        s2_err_d = (s2_adv && s1_v_q) ? err : s2_err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) s2_err_q <= 1'b0;
        else       s2_err_q <= s2_err_d;
    end

    assign bus.out_err = s2_err_q;
`endif

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_v_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_op    = s2_op_q;
endmodule
